fft_stage_sequencer: RTL and testbench

- Sequences the radix-2 butterfly datapath through a complete in-place decimation-in-time FFT of N = 2^LOG2N points.
- Per cycle, issues one butterfly: sample-RAM read address pair, butterfly enable, and twiddle index k with size N for the twiddle/CORDIC path.
- Issues the matching write-back address pair BF_LAT cycles later.
- Sits between the sample RAM and the butterfly. Input data is already bit-reversed in RAM.

---
 rtl/fft_stage_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// Address and control sequencer for an in-place radix-2 DIT FFT.
// Walks every stage of an N = 2^LOG2N point transform, issuing one butterfly
// per cycle (read pair + twiddle index), and replays each read pair as a
// write-back pair BF_LAT non-stalled cycles later.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs quiet
// ST_ISSUE | one butterfly per cycle, j = 0..N/2-1 within stage s
// ST_DRAIN | BF_LAT idle cycles so stage s write-back lands before s+1 reads
// ST_DONE  | single-cycle completion pulse (stretched by hold)
module fft_stage_sequencer #(
    parameter int LOG2N  = 3,
    parameter int BF_LAT = 2
) (
    input  logic             c,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             bf_e,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-1:0] tw_k,
    output logic [LOG2N:0]   tw_n,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [LOG2N-1:0] stage
);

    // Drain counter only has to hold BF_LAT-1.
    localparam int CW = (BF_LAT < 2) ? 1 : $clog2(BF_LAT);

    localparam logic [LOG2N:0]   N_VAL    = {1'b1, {LOG2N{1'b0}}};
    localparam logic [LOG2N-1:0] J_LAST   = {1'b0, {(LOG2N-1){1'b1}}};
    localparam logic [LOG2N-1:0] S_LAST   = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE      = LOG2N'(1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(BF_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q;
    state_t           state_nx;
    logic [LOG2N-1:0] s_q;
    logic [LOG2N-1:0] s_nx;
    logic [LOG2N-1:0] j_q;
    logic [LOG2N-1:0] j_nx;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_nx;

    logic [LOG2N-1:0] rd_a_q;
    logic [LOG2N-1:0] rd_b_q;
    logic [LOG2N-1:0] twk_q;

    logic [LOG2N-1:0] half_nx;
    logic [LOG2N-1:0] mask_nx;
    logic [LOG2N-1:0] pos_nx;
    logic [LOG2N-1:0] addr_a_nx;
    logic [LOG2N-1:0] addr_b_nx;
    logic [LOG2N-1:0] twk_nx;

    logic             dl_v [BF_LAT];
    logic [LOG2N-1:0] dl_a [BF_LAT];
    logic [LOG2N-1:0] dl_b [BF_LAT];

    logic issue_now;

    assign issue_now = (state_q == ST_ISSUE);

    // Next-state logic: stage/butterfly counters and the drain down-counter.
    always_comb begin
        state_nx = state_q;
        s_nx     = s_q;
        j_nx     = j_q;
        cnt_nx   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_ISSUE;
                    s_nx     = '0;
                    j_nx     = '0;
                end
            end
            ST_ISSUE: begin
                if (j_q == J_LAST) begin
                    state_nx = ST_DRAIN;
                    cnt_nx   = CNT_LOAD;
                end else begin
                    j_nx = j_q + ONE;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    if (s_q == S_LAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_ISSUE;
                        s_nx     = s_q + ONE;
                        j_nx     = '0;
                    end
                end else begin
                    cnt_nx = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Butterfly addressing for the next issue slot: the low s bits of j are the
    // position inside the group, the rest is the group index shifted up one to
    // leave room for the leg-select bit (half).
    always_comb begin
        half_nx   = ONE << s_nx;
        mask_nx   = half_nx - ONE;
        pos_nx    = j_nx & mask_nx;
        addr_a_nx = ((j_nx & ~mask_nx) << 1) | pos_nx;
        addr_b_nx = addr_a_nx | half_nx;
        twk_nx    = pos_nx << (S_LAST - s_nx);
    end

    // Sequencer state and registered read/twiddle outputs; hold freezes all.
    always_ff @(posedge c) begin
        if (rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            twk_q   <= '0;
        end else if (!hold) begin
            state_q <= state_nx;
            s_q     <= s_nx;
            j_q     <= j_nx;
            cnt_q   <= cnt_nx;
            if (state_nx == ST_ISSUE) begin
                rd_a_q <= addr_a_nx;
                rd_b_q <= addr_b_nx;
                twk_q  <= twk_nx;
            end
        end
    end

    // Write-back delay line; shifts only on non-stalled cycles so the read to
    // write distance is BF_LAT cycles of real progress.
    always_ff @(posedge c) begin
        if (rst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                dl_v[i] <= 1'b0;
                dl_a[i] <= '0;
                dl_b[i] <= '0;
            end
        end else if (!hold) begin
            dl_v[0] <= issue_now;
            dl_a[0] <= rd_a_q;
            dl_b[0] <= rd_b_q;
            for (int i = 1; i < BF_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_b[i] <= dl_b[i-1];
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign bf_e      = issue_now && !hold;
    assign rd_addr_a = rd_a_q;
    assign rd_addr_b = rd_b_q;
    assign tw_k      = twk_q;
    assign tw_n      = N_VAL;
    assign stage     = s_q;
    assign wr_en     = dl_v[BF_LAT-1] && !hold;
    assign wr_addr_a = dl_a[BF_LAT-1];
    assign wr_addr_b = dl_b[BF_LAT-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: an 8-point, BF_LAT=2 sequencer driven through nominal,
// stalled and start-pulse scenarios from a table, hand sequences for reset
// abort and start held through DONE, and a 4-point, BF_LAT=1 instance checked
// against a per-cycle expected table.
module tb_fft_stage_sequencer;

    logic c = 1'b0;
    always #5 c = ~c;

    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic       busy, done, bf_e, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, tw_k, wr_addr_a, wr_addr_b, stage;
    logic [3:0] tw_n;

    logic       start2 = 1'b0;
    logic       hold2 = 1'b0;
    logic       busy2, done2, bf_e2, wr_en2;
    logic [1:0] rd_addr_a2, rd_addr_b2, tw_k2, wr_addr_a2, wr_addr_b2, stage2;
    logic [2:0] tw_n2;

    fft_stage_sequencer #(.LOG2N(3), .BF_LAT(2)) dut (
        .c(c), .rst(rst), .start(start), .hold(hold),
        .busy(busy), .done(done), .bf_e(bf_e),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .tw_k(tw_k), .tw_n(tw_n),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .stage(stage)
    );

    fft_stage_sequencer #(.LOG2N(2), .BF_LAT(1)) dut_small (
        .c(c), .rst(rst), .start(start2), .hold(hold2),
        .busy(busy2), .done(done2), .bf_e(bf_e2),
        .rd_addr_a(rd_addr_a2), .rd_addr_b(rd_addr_b2),
        .tw_k(tw_k2), .tw_n(tw_n2),
        .wr_en(wr_en2), .wr_addr_a(wr_addr_a2), .wr_addr_b(wr_addr_b2),
        .stage(stage2)
    );

    int n_chk = 0;
    int n_err = 0;
    int tcur  = 0;
    int scen  = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] k;
    } bfly_t;

    typedef struct {
        int h0;
        int h1;
        int sp1;
        int sp2;
        int done_cyc;
    } scen_t;

    typedef struct {
        logic       bf;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] k;
        logic       wr;
        logic [1:0] wa;
        logic [1:0] wb;
        logic       dn;
        logic       bs;
    } svec_t;

    bfly_t rd_tab [12];
    scen_t sc [3];
    svec_t sv [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s scen=%0d cycle=%0d actual=%0d expected=%0d", nm, scen, tcur, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge c);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        rst    = 1'b1;
        start  = 1'b0;
        hold   = 1'b0;
        start2 = 1'b0;
        next_cycle();
        rst = 1'b0;
    endtask

    // Logical cycle (stall cycles removed) at which butterfly i is read.
    function automatic int rd_idx(input int lc);
        for (int i = 0; i < 12; i++) begin
            if (1 + (i / 4) * 6 + (i % 4) == lc) return i;
        end
        return -1;
    endfunction

    function automatic int exp_stage(input int lc);
        if (lc <= 6) return 0;
        if (lc <= 12) return 1;
        return 2;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", tcur);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hcnt;
        int lc;
        int ri;
        int wi;
        logic held;

        rd_tab[0]  = '{3'd0, 3'd1, 3'd0};
        rd_tab[1]  = '{3'd2, 3'd3, 3'd0};
        rd_tab[2]  = '{3'd4, 3'd5, 3'd0};
        rd_tab[3]  = '{3'd6, 3'd7, 3'd0};
        rd_tab[4]  = '{3'd0, 3'd2, 3'd0};
        rd_tab[5]  = '{3'd1, 3'd3, 3'd2};
        rd_tab[6]  = '{3'd4, 3'd6, 3'd0};
        rd_tab[7]  = '{3'd5, 3'd7, 3'd2};
        rd_tab[8]  = '{3'd0, 3'd4, 3'd0};
        rd_tab[9]  = '{3'd1, 3'd5, 3'd1};
        rd_tab[10] = '{3'd2, 3'd6, 3'd2};
        rd_tab[11] = '{3'd3, 3'd7, 3'd3};

        sc[0] = '{-1, -2, -1, -1, 19};
        sc[1] = '{ 3,  5, -1, -1, 22};
        sc[2] = '{-1, -2,  5, 12, 19};

        sv[0] = '{1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
        sv[1] = '{1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        sv[2] = '{1'b1, 2'd2, 2'd3, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b1};
        sv[3] = '{1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b1};
        sv[4] = '{1'b1, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1};
        sv[5] = '{1'b1, 2'd1, 2'd3, 2'd1, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1};
        sv[6] = '{1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 2'd3, 1'b0, 1'b1};
        sv[7] = '{1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1};
        sv[8] = '{1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};

        // Table-driven runs of the 8-point instance.
        for (int si = 0; si < 3; si++) begin
            scen = si;
            do_reset();
            hcnt = 0;
            for (int t = 0; t <= 24; t++) begin
                if (t > 0) next_cycle();
                tcur  = t;
                held  = (t >= sc[si].h0) && (t <= sc[si].h1);
                start = (t == 0) || (t == sc[si].sp1) || (t == sc[si].sp2);
                hold  = held;
                lc    = t - hcnt;
                @(negedge c);
                ri = rd_idx(lc);
                wi = rd_idx(lc - 2);
                if (t == 0) begin
                    chk("reset_rd_a", rd_addr_a, 0);
                    chk("reset_rd_b", rd_addr_b, 0);
                    chk("reset_tw_k", tw_k, 0);
                    chk("reset_wr_a", wr_addr_a, 0);
                    chk("reset_wr_b", wr_addr_b, 0);
                end
                chk("bf_e", bf_e, (!held && ri >= 0) ? 1 : 0);
                if (ri >= 0) begin
                    chk("rd_a", rd_addr_a, rd_tab[ri].a);
                    chk("rd_b", rd_addr_b, rd_tab[ri].b);
                    chk("tw_k", tw_k, rd_tab[ri].k);
                end
                chk("wr_en", wr_en, (!held && wi >= 0) ? 1 : 0);
                if (wi >= 0) begin
                    chk("wr_a", wr_addr_a, rd_tab[wi].a);
                    chk("wr_b", wr_addr_b, rd_tab[wi].b);
                end
                chk("done", done, (lc == 19) ? 1 : 0);
                chk("busy", busy, (lc >= 1 && lc <= 19) ? 1 : 0);
                chk("stage", stage, exp_stage(lc));
                chk("tw_n", tw_n, 8);
                if (t == sc[si].done_cyc) chk("done_at_cycle", done, 1);
                if (held) hcnt++;
            end
        end

        // Reset mid-run with write-backs still in the delay line.
        scen = 3;
        do_reset();
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) next_cycle();
            tcur  = t;
            start = (t == 0) || (t == 10);
            rst   = (t == 8);
            @(negedge c);
            if (t == 8) begin
                chk("pre_rst_bf_e", bf_e, 1);
                chk("pre_rst_rd_a", rd_addr_a, 1);
                chk("pre_rst_rd_b", rd_addr_b, 3);
            end
            if (t == 9) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_bf_e", bf_e, 0);
                chk("rst_rd_a", rd_addr_a, 0);
                chk("rst_rd_b", rd_addr_b, 0);
                chk("rst_tw_k", tw_k, 0);
                chk("rst_wr_a", wr_addr_a, 0);
                chk("rst_wr_b", wr_addr_b, 0);
                chk("rst_stage", stage, 0);
                chk("rst_tw_n", tw_n, 8);
            end
            if (t >= 9) chk("rst_wr_en", wr_en, 0);
            if (t == 10) chk("rst_bf_e_idle", bf_e, 0);
            if (t == 11) begin
                chk("restart_bf_e", bf_e, 1);
                chk("restart_rd_a", rd_addr_a, 0);
                chk("restart_rd_b", rd_addr_b, 1);
                chk("restart_stage", stage, 0);
                chk("restart_busy", busy, 1);
            end
            if (t == 12) begin
                chk("restart_rd_a2", rd_addr_a, 2);
                chk("restart_rd_b2", rd_addr_b, 3);
            end
        end

        // start held high for the whole run and beyond.
        scen = 4;
        do_reset();
        for (int t = 0; t <= 21; t++) begin
            if (t > 0) next_cycle();
            tcur  = t;
            start = 1'b1;
            @(negedge c);
            if (t == 5 || t == 12 || t == 18) chk("held_start_drain", bf_e, 0);
            if (t == 7) chk("held_start_rd_b", rd_addr_b, 2);
            if (t == 19) begin
                chk("held_start_done", done, 1);
                chk("held_start_busy", busy, 1);
            end
            if (t == 20) begin
                chk("held_start_idle_busy", busy, 0);
                chk("held_start_idle_bf_e", bf_e, 0);
                chk("held_start_idle_done", done, 0);
            end
            if (t == 21) begin
                chk("rerun_bf_e", bf_e, 1);
                chk("rerun_rd_a", rd_addr_a, 0);
                chk("rerun_rd_b", rd_addr_b, 1);
                chk("rerun_stage", stage, 0);
            end
        end

        // 4-point, BF_LAT=1 instance against its per-cycle table.
        scen = 5;
        do_reset();
        start = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            if (t > 0) next_cycle();
            tcur   = t;
            start2 = (t == 0);
            @(negedge c);
            chk("s_bf_e", bf_e2, sv[t].bf);
            if (sv[t].bf) begin
                chk("s_rd_a", rd_addr_a2, sv[t].a);
                chk("s_rd_b", rd_addr_b2, sv[t].b);
                chk("s_tw_k", tw_k2, sv[t].k);
            end
            chk("s_wr_en", wr_en2, sv[t].wr);
            if (sv[t].wr) begin
                chk("s_wr_a", wr_addr_a2, sv[t].wa);
                chk("s_wr_b", wr_addr_b2, sv[t].wb);
            end
            chk("s_done", done2, sv[t].dn);
            chk("s_busy", busy2, sv[t].bs);
            chk("s_tw_n", tw_n2, 4);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
